ecg_playback_ctrl: RTL and testbench



---
 rtl/ecg_pkg.sv | 26 ++
 rtl/ecg_playback_ctrl_if.sv | 39 +++
 rtl/ecg_tick_gen.sv | 38 +++
 rtl/ecg_playback_ctrl.sv | 152 +++++++++++++++
 tb/tb_ecg_playback_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecg_pkg.sv
// Shared types and constants for the ECG recording playback path.
package ecg_pkg;

    localparam int ECG_DATA_WIDTH = 11;   // MIT-BIH sample width
    localparam int ECG_ADDR_WIDTH = 15;   // holds a 21600-sample record
    localparam int ECG_DIV_WIDTH  = 24;   // clk cycles per sample period
    localparam int MITBIH_FS      = 360;  // native sample rate in Hz

    typedef logic [ECG_DATA_WIDTH-1:0] sample_t;
    typedef logic [ECG_ADDR_WIDTH-1:0] saddr_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        DATA,
        HOLD,
        DONE
    } play_state_t;

    // States in which playback is in progress and the pacing divider runs.
    function automatic logic is_running(input play_state_t s);
        return (s == WAIT) || (s == READ) || (s == DATA) || (s == HOLD);
    endfunction

endpackage

// File: rtl/ecg_playback_ctrl_if.sv
// Memory read port and sample stream between the playback controller and
// its environment (recording memory on one side, alg_core on the other).
//
// Sample stream: sample_out/sample_idx are valid while sample_valid=1 and are
// held stable until a cycle with sample_valid=1 and sample_ready=1; that
// cycle is the one and only transfer of the sample. The memory port returns
// mem_data exactly one cycle after a cycle with mem_rd=1.
interface ecg_playback_ctrl_if
    import ecg_pkg::*;
#(
    parameter int DATA_WIDTH = ECG_DATA_WIDTH,
    parameter int ADDR_WIDTH = ECG_ADDR_WIDTH
) ();

    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] sample_out;
    logic [ADDR_WIDTH-1:0] sample_idx;
    logic                  sample_valid;
    logic                  sample_ready;

    // Controller side.
    modport master (
        output mem_rd, mem_addr,
        input  mem_data,
        output sample_out, sample_idx, sample_valid,
        input  sample_ready
    );

    // Memory + core side.
    modport slave (
        input  mem_rd, mem_addr,
        output mem_data,
        input  sample_out, sample_idx, sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/ecg_tick_gen.sv
// Loadable pacing divider: emits one tick every div_q enabled cycles.
// A divider value of 0 is treated as 1 (tick every cycle).
module ecg_tick_gen
    import ecg_pkg::*;
#(
    parameter int DIV_WIDTH = ECG_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_load,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_div_q;
    logic [DIV_WIDTH-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == (r_div_q - DIV_WIDTH'(1)));

    // Latch the divider on load, otherwise count enabled cycles and wrap on tick.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cnt   <= '0;
            r_div_q <= DIV_WIDTH'(1);
        end else if (i_load) begin
            r_cnt   <= '0;
            r_div_q <= (i_div == '0) ? DIV_WIDTH'(1) : i_div;
        end else if (i_en) begin
            if (o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ecg_playback_ctrl.sv
// Paced playback of a stored ECG record: one memory read per pacing tick,
// each sample handed to the core over valid/ready. One-shot or looped.
module ecg_playback_ctrl
    import ecg_pkg::*;
#(
    parameter int DATA_WIDTH = ECG_DATA_WIDTH,
    parameter int ADDR_WIDTH = ECG_ADDR_WIDTH,
    parameter int DIV_WIDTH  = ECG_DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_loop_en,
    input  logic [ADDR_WIDTH-1:0] i_length,
    input  logic [DIV_WIDTH-1:0]  i_div,
    ecg_playback_ctrl_if.master   bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overrun,
    output play_state_t           o_state
);

    play_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_length_q;
    logic                  r_loop_q;
    logic                  r_mem_rd;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_sample_out;
    logic [ADDR_WIDTH-1:0] r_sample_idx;
    logic                  r_sample_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overrun;

    logic w_running;
    logic w_load;
    logic w_tick;
    logic w_last;

    assign w_running = is_running(r_state);
    assign w_load    = i_start && !w_running;
    assign w_last    = (r_addr == (r_length_q - ADDR_WIDTH'(1)));

    ecg_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .clk    (clk),
        .nrst   (nrst),
        .i_load (w_load),
        .i_en   (w_running),
        .i_div  (i_div),
        .o_tick (w_tick)
    );

    assign bus.mem_rd       = r_mem_rd;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.sample_out   = r_sample_out;
    assign bus.sample_idx   = r_sample_idx;
    assign bus.sample_valid = r_sample_valid;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_overrun        = r_overrun;
    assign o_state          = r_state;

    // Playback sequencer with registered outputs; stop overrides everything
    // while running, and a tick that finds a read still in flight is lost.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_length_q     <= '0;
            r_loop_q       <= 1'b0;
            r_mem_rd       <= 1'b0;
            r_mem_addr     <= '0;
            r_sample_out   <= '0;
            r_sample_idx   <= '0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_mem_rd <= 1'b0;
            if (w_tick && (r_state == READ || r_state == DATA || r_state == HOLD)) begin
                r_overrun <= 1'b1;
            end
            if (w_running && i_stop) begin
                r_state        <= IDLE;
                r_sample_valid <= 1'b0;
                r_busy         <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (i_start) begin
                            r_length_q <= i_length;
                            r_loop_q   <= i_loop_en;
                            r_addr     <= '0;
                            r_overrun  <= 1'b0;
                            if (i_length == '0) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= WAIT;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (w_tick) begin
                            r_state    <= READ;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= r_addr;
                        end
                    end
                    READ: begin
                        r_state <= DATA;
                    end
                    DATA: begin
                        r_sample_out   <= bus.mem_data;
                        r_sample_idx   <= r_addr;
                        r_sample_valid <= 1'b1;
                        r_state        <= HOLD;
                    end
                    HOLD: begin
                        if (bus.sample_ready) begin
                            r_sample_valid <= 1'b0;
                            if (w_last && r_loop_q) begin
                                r_addr  <= '0;
                                r_state <= WAIT;
                            end else if (w_last) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_addr  <= r_addr + ADDR_WIDTH'(1);
                                r_state <= WAIT;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecg_playback_ctrl.sv
// Directed bench for ecg_playback_ctrl: memory model with data[i]=100+i,
// scoreboard of expected (idx, sample) pairs popped on every transfer.
module tb_ecg_playback_ctrl;
    import ecg_pkg::*;

    localparam int DW  = ECG_DATA_WIDTH;
    localparam int AW  = ECG_ADDR_WIDTH;
    localparam int DVW = ECG_DIV_WIDTH;
    localparam int W   = AW + DW;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           nrst;
    logic           i_start;
    logic           i_stop;
    logic           i_loop_en;
    logic [AW-1:0]  i_length;
    logic [DVW-1:0] i_div;
    logic           o_busy;
    logic           o_done;
    logic           o_overrun;
    play_state_t    o_state;

    ecg_playback_ctrl_if bus ();

    ecg_playback_ctrl dut (
        .clk       (clk),
        .nrst      (nrst),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_loop_en (i_loop_en),
        .i_length  (i_length),
        .i_div     (i_div),
        .bus       (bus),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_overrun (o_overrun),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Recording memory: synchronous read, data one cycle after mem_rd.
    sample_t mem [0:31];
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr[4:0]];
    end

    // ---------------- scoreboard / counters ----------------
    logic [W-1:0] exp_q[$];
    int           hs_cyc_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           done_cnt = 0;
    int           rd_cnt = 0;
    int           d0;
    int           r0;
    int           k;
    int           changes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp++;
        n_fail++;
        $error("FAIL timeout_%s: observed=no event expected=event within budget", tag);
    endtask

    task automatic push_exp(input int idx);
        exp_q.push_back({saddr_t'(idx), sample_t'(100 + idx)});
    endtask

    // Monitor: runs just after the negedge so it sees inputs driven there.
    always @(negedge clk) begin
        logic [W-1:0] e;
        #1;
        if (nrst) begin
            if (o_done) done_cnt++;
            if (bus.mem_rd) rd_cnt++;
            if (bus.sample_valid && bus.sample_ready) begin
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL sb_underflow: observed idx=%0d expected no transfer", bus.sample_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_idx", 32'(bus.sample_idx), 32'(e[W-1:DW]));
                    check("sb_data", 32'(bus.sample_out), 32'(e[DW-1:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cfg(input int len, input int dv, input logic lp);
        i_length  = AW'(len);
        i_div     = DVW'(dv);
        i_loop_en = lp;
    endtask

    task automatic snap();
        @(negedge clk);
        #2;
        d0 = done_cnt;
        r0 = rd_cnt;
    endtask

    // Leaves the bench at the negedge of the first cycle after the start edge.
    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget, output int n);
        n = 0;
        while (!bus.sample_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.sample_valid) timeout_fail(tag);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!o_done) timeout_fail(tag);
    endtask

    task automatic wait_hs(input string tag, input int cnt_req, input int budget);
        int cnt = 0;
        int n = 0;
        while (cnt < cnt_req && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.sample_valid && bus.sample_ready) cnt++;
        end
        if (cnt < cnt_req) timeout_fail(tag);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_mem_rd"},   32'(bus.mem_rd),       0);
        check({pfx, "_mem_addr"}, 32'(bus.mem_addr),     0);
        check({pfx, "_sample"},   32'(bus.sample_out),   0);
        check({pfx, "_idx"},      32'(bus.sample_idx),   0);
        check({pfx, "_valid"},    32'(bus.sample_valid), 0);
        check({pfx, "_busy"},     32'(o_busy),           0);
        check({pfx, "_done"},     32'(o_done),           0);
        check({pfx, "_overrun"},  32'(o_overrun),        0);
        check({pfx, "_state"},    32'(o_state),          32'(IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = sample_t'(100 + i);
        nrst             = 1'b0;
        i_start          = 1'b0;
        i_stop           = 1'b0;
        bus.sample_ready = 1'b1;
        cfg(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        nrst = 1'b1;

        // One-shot: 5 samples, 10 cycles apart, first valid 13 cycles after start.
        cfg(5, 10, 1'b0);
        for (int i = 0; i < 5; i++) push_exp(i);
        snap();
        hs_cyc_q.delete();
        pulse_start();
        check("t1_busy_after_start", 32'(o_busy), 1);
        wait_valid("t1_first_valid", 50, k);
        check("t1_first_valid_cycle", 32'(k + 1), 13);
        wait_done("t1_done", 100);
        check("t1_busy_with_done", 32'(o_busy), 0);
        check("t1_overrun", 32'(o_overrun), 0);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(o_done), 0);
        #2;
        check("t1_done_count", 32'(done_cnt), 32'(d0 + 1));
        check("t1_hs_count", 32'(hs_cyc_q.size()), 5);
        for (int i = 1; i < hs_cyc_q.size(); i++)
            check("t1_spacing", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 10);
        check("t1_sb_empty", 32'(exp_q.size()), 0);

        // Loop: idx 0,1,2,0,1,2,0 then stop.
        cfg(3, 8, 1'b1);
        for (int i = 0; i < 7; i++) push_exp(i % 3);
        snap();
        pulse_start();
        wait_hs("t2_hs", 7, 200);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check("t2_busy_after_stop", 32'(o_busy), 0);
        check("t2_state_after_stop", 32'(o_state), 32'(IDLE));
        check("t2_valid_after_stop", 32'(bus.sample_valid), 0);
        #2;
        check("t2_no_done", 32'(done_cnt), 32'(d0));
        check("t2_sb_empty", 32'(exp_q.size()), 0);

        // Backpressure on sample 2 with div=4.
        cfg(5, 4, 1'b0);
        for (int i = 0; i < 5; i++) push_exp(i);
        snap();
        pulse_start();
        wait_hs("t3_hs", 2, 100);
        @(negedge clk);
        bus.sample_ready = 1'b0;
        wait_valid("t3_valid2", 20, k);
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.sample_out !== sample_t'(102) || bus.sample_valid !== 1'b1) changes++;
            @(negedge clk);
        end
        check("t3_hold_stable", 32'(changes), 0);
        check("t3_hold_idx", 32'(bus.sample_idx), 2);
        check("t3_overrun_set", 32'(o_overrun), 1);
        bus.sample_ready = 1'b1;
        wait_done("t3_done", 100);
        check("t3_overrun_sticky", 32'(o_overrun), 1);
        @(negedge clk);
        #2;
        check("t3_sb_empty", 32'(exp_q.size()), 0);
        check("t3_done_count", 32'(done_cnt), 32'(d0 + 1));

        // length=0: done right away, no memory read.
        cfg(0, 10, 1'b0);
        snap();
        pulse_start();
        check("t4_len0_done", 32'(o_done), 1);
        check("t4_len0_state", 32'(o_state), 32'(DONE));
        check("t4_len0_busy", 32'(o_busy), 0);
        repeat (3) @(negedge clk);
        #2;
        check("t4_len0_no_rd", 32'(rd_cnt), 32'(r0));
        check("t4_len0_done_count", 32'(done_cnt), 32'(d0 + 1));

        // div=0 behaves as div=1 and overruns on the first sample.
        cfg(2, 0, 1'b0);
        push_exp(0);
        push_exp(1);
        snap();
        pulse_start();
        wait_valid("t4_div0_valid", 20, k);
        check("t4_div0_first_valid_cycle", 32'(k + 1), 4);
        check("t4_div0_overrun", 32'(o_overrun), 1);
        wait_done("t4_div0_done", 50);
        @(negedge clk);
        #2;
        check("t4_div0_sb_empty", 32'(exp_q.size()), 0);

        // Stop while holding a sample, then restart.
        cfg(4, 6, 1'b0);
        bus.sample_ready = 1'b0;
        snap();
        pulse_start();
        wait_valid("t5_valid", 30, k);
        repeat (10) @(negedge clk);
        check("t5_overrun_before_stop", 32'(o_overrun), 1);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check("t5_valid_after_stop", 32'(bus.sample_valid), 0);
        check("t5_state_after_stop", 32'(o_state), 32'(IDLE));
        cfg(2, 5, 1'b0);
        bus.sample_ready = 1'b1;
        push_exp(0);
        push_exp(1);
        snap();
        pulse_start();
        check("t5_overrun_cleared", 32'(o_overrun), 0);
        wait_hs("t5_hs", 1, 50);
        cfg(7, 5, 1'b1);
        pulse_start();
        check("t5_busy_ignored_start", 32'(o_busy), 1);
        wait_done("t5_done", 100);
        @(negedge clk);
        #2;
        check("t5_sb_empty", 32'(exp_q.size()), 0);
        check("t5_done_count", 32'(done_cnt), 32'(d0 + 1));

        // Reset during DATA.
        cfg(3, 5, 1'b0);
        snap();
        pulse_start();
        k = 0;
        while (o_state != DATA && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (o_state != DATA) timeout_fail("t6_data");
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check_all_zero("t6");
        repeat (3) @(negedge clk);
        #2;
        check("t6_no_done", 32'(done_cnt), 32'(d0));
        check("t6_idle_after", 32'(o_busy), 0);
        check("t6_sb_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
